// File: rtl/msg_serializer_if.sv
// Message-source <-> serializer handshake bundle: send/abort/message in, ready/data/valid/done out.
// Pure wiring, no latency; the serializer drops any send it sees while ready=0.
// The serializer takes the slave modport and the message source takes the master modport.
interface msg_serializer_if #(
    parameter int MSG_W = 5
);
    logic             send;
    logic             abort;
    logic [MSG_W-1:0] message;
    logic             ready;
    logic             data;
    logic             valid;
    logic             done;

    modport master (
        output send, abort, message,
        input  ready, data, valid, done
    );

    modport slave (
        input  send, abort, message,
        output ready, data, valid, done
    );
endinterface

// File: rtl/msg_serializer.sv
// Frames {HEADER, message, optional parity} and shifts it out one bit per BAUD_DIV clocks.
// Latency: first frame bit on data the cycle after accept; done pulses the cycle after the last bit.
// Backpressure: send is only taken while ready=1; anything offered while busy is dropped, not queued.
module msg_serializer #(
    parameter int                 MSG_W     = 5,
    parameter int                 HDR_W     = 4,
    parameter logic [HDR_W-1:0]   HEADER    = 4'b0101,
    parameter int                 BAUD_DIV  = 10,
    parameter int                 PAR_EN    = 0,
    parameter int                 PAR_ODD   = 0,
    parameter int                 MSB_FIRST = 1,
    parameter int                 IDLE_LVL  = 0
) (
    input  logic              clk,
    input  logic              rst,
    msg_serializer_if.slave   bus
);
    localparam int F    = HDR_W + MSG_W + PAR_EN;
    localparam int FULL = HDR_W + MSG_W + 1;
    localparam int BW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int FW   = (F > 1) ? $clog2(F) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state, state_d;
    logic [F-1:0]    sreg;
    logic [BW-1:0]   baud_cnt;
    logic [FW-1:0]   bit_cnt;
    logic            done_q;

    logic            accept;
    logic            fin;
    logic            wrap;
    logic            last_bit;

    logic [HDR_W-1:0] hdr_seq;
    logic [MSG_W-1:0] pay_seq;
    logic             par;
    logic [FULL-1:0]  full;
    logic [F-1:0]     frame;

    // Frame is stored in transmit order so the outgoing bit is always sreg[F-1].
    always_comb begin
        for (int k = 0; k < HDR_W; k++)
            hdr_seq[k] = (MSB_FIRST != 0) ? HEADER[k] : HEADER[HDR_W-1-k];
        for (int k = 0; k < MSG_W; k++)
            pay_seq[k] = (MSB_FIRST != 0) ? bus.message[k] : bus.message[MSG_W-1-k];
        par   = (^bus.message) ^ PAR_ODD[0];
        full  = {hdr_seq, pay_seq, par};
        // Without parity the trailing bit is shifted away and the frame is one bit shorter.
        frame = F'(full >> (1 - PAR_EN));
    end

    assign wrap     = (baud_cnt == BW'(BAUD_DIV - 1));
    assign last_bit = (bit_cnt == FW'(F - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        fin     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.send && !bus.abort) begin
                    accept  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (wrap && last_bit) begin
                    state_d = IDLE;
                    fin     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg     <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= fin;
            if (accept) begin
                sreg     <= frame;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (state == SEND && !bus.abort) begin
                if (wrap) begin
                    baud_cnt <= '0;
                    sreg     <= sreg << 1;
                    bit_cnt  <= bit_cnt + 1'b1;
                end else begin
                    baud_cnt <= baud_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.valid = (state == SEND);
    assign bus.data  = (state == SEND) ? sreg[F-1] : IDLE_LVL[0];
    assign bus.done  = done_q;
endmodule
